// File: rtl/vram_ctrl.sv
// vram_ctrl: CPU window into video RAM plus a hardware fill engine.
// The CPU window (io_addr[15:12]==4'h8) always wins over the fill engine;
// the engine stalls for one cycle whenever the CPU writes the window.
// Optional build macro VRAM_CTRL_IRQ_EN enables the sticky fill-complete flag
// (fill_irq / STATUS bit2); without it both read as 0.
module vram_ctrl #(
   parameter int AW = 11,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [15:0]   io_addr,
   input  logic [15:0]   io_dout,
   input  logic          io_wr,
   input  logic          io_rd,
   output logic [15:0]   io_din,
   output logic          vram_we,
   output logic [AW-1:0] vram_waddr,
   output logic [DW-1:0] vram_wdata,
   output logic          fill_irq
);

   typedef enum logic {IDLE, FILL} state_t;

   localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};

   state_t        state;
   logic [AW-1:0] faddr;
   logic [AW:0]   flen;
   logic [AW-1:0] ptr;
   logic [AW:0]   rem;
   logic [DW-1:0] value;
   logic          overrun;

   logic          win_wr;
   logic          faddr_wr;
   logic          flen_wr;
   logic          fgo_wr;
   logic          status_rd;
   logic [AW:0]   flen_in;
   logic          ovr_set;
   logic          busy;

   assign win_wr    = io_wr && (io_addr[15:12] == 4'h8);
   assign faddr_wr  = io_wr && (io_addr == 16'hF100);
   assign flen_wr   = io_wr && (io_addr == 16'hF101);
   assign fgo_wr    = io_wr && (io_addr == 16'hF102);
   assign status_rd = io_rd && (io_addr == 16'hF103);
   assign busy      = (state == FILL);
   assign ovr_set   = fgo_wr && (state == FILL);

   // Clamp fill length to a full sweep of the RAM
   always_comb begin
      flen_in = (AW+1)'(io_dout);
      if (32'(io_dout) > 32'(LEN_MAX))
         flen_in = LEN_MAX;
   end

`ifdef VRAM_CTRL_IRQ_EN
   logic irq_q;
   logic irq_set;

   // Fill completes either on the last engine write or on a zero-length start
   always_comb begin
      irq_set = 1'b0;
      if (state == IDLE && fgo_wr && flen == '0)
         irq_set = 1'b1;
      if (state == FILL && !win_wr && rem == (AW+1)'(1))
         irq_set = 1'b1;
   end

   // Sticky completion flag: set wins over a same-cycle STATUS read clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         irq_q <= 1'b0;
      else if (irq_set)
         irq_q <= 1'b1;
      else if (status_rd)
         irq_q <= 1'b0;
   end

   assign fill_irq = irq_q;
`else
   assign fill_irq = 1'b0;
`endif

   // STATUS readback, combinational on the read strobe
   always_comb begin
      io_din = '0;
      if (status_rd)
         io_din = {13'h0000, fill_irq, overrun, busy};
   end

   // Register file, fill FSM and registered video RAM write port
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         faddr      <= '0;
         flen       <= '0;
         ptr        <= '0;
         rem        <= '0;
         value      <= '0;
         overrun    <= 1'b0;
         vram_we    <= 1'b0;
         vram_waddr <= '0;
         vram_wdata <= '0;
      end else begin
         vram_we <= 1'b0;
         if (faddr_wr)
            faddr <= AW'(io_dout);
         if (flen_wr)
            flen <= flen_in;

         if (ovr_set)
            overrun <= 1'b1;
         else if (status_rd)
            overrun <= 1'b0;

         if (win_wr) begin
            vram_we    <= 1'b1;
            vram_waddr <= AW'(io_addr);
            vram_wdata <= DW'(io_dout);
         end

         case (state)
            IDLE: begin
               if (fgo_wr && flen != '0) begin
                  value <= DW'(io_dout);
                  ptr   <= faddr;
                  rem   <= flen;
                  state <= FILL;
               end
            end
            FILL: begin
               // Engine only advances in cycles the CPU leaves the port free
               if (!win_wr) begin
                  vram_we    <= 1'b1;
                  vram_waddr <= ptr;
                  vram_wdata <= value;
                  ptr        <= ptr + AW'(1);
                  rem        <= rem - (AW+1)'(1);
                  if (rem == (AW+1)'(1))
                     state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/vram_ctrl.md
VRAM_CTRL -- requirements
Module: vram_ctrl

Interface
REQ-001 Parameter AW, 11, video RAM address width.
REQ-002 Parameter DW, 8, video RAM data width.
REQ-003 Port clk  in  1  the only clock; all state changes on its rising edge.
REQ-004 Port reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port io_addr  in  16  CPU I/O address.
REQ-006 Port io_dout  in  16  CPU write data.
REQ-007 Port io_wr  in  1  CPU write strobe, one cycle per access.
REQ-008 Port io_rd  in  1  CPU read strobe.
REQ-009 Port io_din  out  16  read data back to the CPU.
REQ-010 Port vram_we  out  1  video RAM write enable.
REQ-011 Port vram_waddr  out  AW  video RAM write address.
REQ-012 Port vram_wdata  out  DW  video RAM write data.
REQ-013 Port fill_irq  out  1  sticky fill-complete flag.

Function
REQ-014 The CPU window is io_addr[15:12]==4'h8; window write address = io_addr[AW-1:0], data = io_dout[DW-1:0].
REQ-015 Registers: FADDR 0xF100 (W, AW bits); FLEN 0xF101 (W, AW+1 bits); FGO 0xF102 (W, DW-bit fill value, starts a fill); STATUS 0xF103 (R).
REQ-016 FLEN writes above 2^AW are clamped to 2^AW.
REQ-017 STATUS layout: bit0 busy; bit1 overrun; bit2 fill_irq; other bits 0.
REQ-018 io_din is combinational: STATUS when io_rd and io_addr==0xF103, else 16'h0000.
REQ-019 A STATUS read clears overrun and fill_irq on the next edge; a set and a clear in the same cycle resolve to set.
REQ-020 The FSM has two states, IDLE and FILL.
REQ-021 IDLE + FGO write with FLEN!=0: latch value, ptr=FADDR, rem=FLEN, go to FILL.
REQ-022 IDLE + FGO write with FLEN==0: stay in IDLE, no writes, set fill_irq.
REQ-023 FILL, no CPU window write this cycle: engine writes value at ptr; ptr increments modulo 2^AW (0x7FF wraps to 0x000); rem decrements.
REQ-024 FILL, CPU window write this cycle: the CPU write is issued and the engine holds ptr and rem.
REQ-025 The CPU always has priority, so window writes are never dropped or delayed beyond REQ-026 latency.
REQ-026 The vram_* outputs are registered: a write accepted in cycle N appears on vram_we/addr/data in cycle N+1 for exactly one cycle.
REQ-027 When the engine write with rem==1 is issued, the FSM returns to IDLE and fill_irq sets on the same edge.
REQ-028 An FGO write during FILL is dropped and sets overrun; the current fill is unaffected.
REQ-029 FADDR and FLEN writes during FILL update the registers only; they do not change the active ptr or rem.
REQ-030 busy = (state==FILL).
REQ-031 Writes to undecoded addresses and reads of write-only registers have no effect and return 0.

Reset
REQ-032 While reset_n=0: state=IDLE; FADDR, FLEN, ptr, rem and value = 0; overrun and fill_irq = 0; vram_we=0; vram_waddr=0; vram_wdata=0.
REQ-033 Asserting reset_n mid-fill aborts the fill immediately; no further engine writes occur after reset release.

Configuration
REQ-034 Macro VRAM_CTRL_IRQ_EN selects fill-completion reporting.
- Defined: fill_irq port drives the sticky flag per REQ-019/022/027; STATUS bit2 mirrors it.
- Undefined: no flag storage; fill_irq and STATUS bit2 are tied to 0.

Verification
REQ-035 FADDR=0x010, FLEN=4, FGO=0x41 -> writes 0x41 to 0x010..0x013 on four consecutive cycles starting 2 cycles after FGO; busy=0 afterward; fill_irq=1.
REQ-036 FADDR=0x7FE, FLEN=3, FGO=0x20 -> writes to 0x7FE, 0x7FF, 0x000.
REQ-037 During a 4-write fill at 0x100, CPU writes 0x55 to 0x8005 in the 2nd fill cycle -> order is 0x100, 0x005=0x55, 0x101, 0x102, 0x103; fill completes one cycle late.
REQ-038 FGO during an active fill -> STATUS reads 0x0003; the next STATUS read reads 0x0001; the original fill completes unchanged.
REQ-039 FLEN=0x1000 then FGO=0x00 -> exactly 2048 writes covering 0x000..0x7FF once.
REQ-040 reset_n low for 1 cycle after 2 fill writes -> vram_we=0 from assertion onward; STATUS=0x0000; no further writes.
